cla_pipe_addsub: RTL
====================

# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups. Each group uses generate/propagate terms; carries ripple from group to group. The group chain is split into STAGES register-separated segments with a valid/ready handshake on both sides. It is the datapath adder the arithmetic units instantiate when the operand is wider than 16 bits or the combinational carry path must be cut.

## Interface
- WIDTH, 32, operand width; multiple of 4, minimum 4.
- STAGES, 2, pipeline depth in cycles; 1 ≤ STAGES ≤ WIDTH/4, and (WIDTH/4) divisible by STAGES.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts the operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a−b−cin.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry-out; in sub mode, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

## Operation
- Effective operands: B' = sub ? ~b : b; C0 = sub ? ~cin : cin.
- Groups: WIDTH/4 groups of 4 bits.
  - Per bit: p = a^B', g = a&B'.
  - Group carry-out uses the full 4-term lookahead from the group's carry-in.
  - sum bit = p ^ c.
- Segments: GPS = WIDTH/(4·STAGES) groups per segment.
  - Segment k computes groups k·GPS … (k+1)·GPS−1, taking its carry-in from segment k−1's registered carry.
  - Segment k runs in pipeline stage k.
- Operand skew:
  - A and B' bits for segment k are delayed k cycles alongside the data.
  - Completed sum bits of earlier segments are carried forward to the output register.
- ovf: carry into MSB XOR carry out of MSB, computed in the last stage.
- zero: NOR of all final sum bits, computed from the output-stage data.
- sub, a, b and cin are captured only on an accepted transfer; later input changes do not affect in-flight items.
- Handshake:
  - Global advance: adv = !out_valid || out_ready.
  - in_ready = adv.
  - On adv, every stage register loads from its predecessor, including its valid bit.
  - Stage 0 loads in_valid && in_ready.
  - When !adv, all stages hold.
  - Bubbles (valid=0) propagate and are squeezed out only at the output when out_valid=0.
- An output transfer occurs when out_valid && out_ready.

## Timing
- Latency: an item accepted on edge n appears with out_valid=1 after edge n+STAGES−1, i.e. STAGES cycles from acceptance to presentation. With STAGES=1, the result is registered one cycle after acceptance.
- Throughput: one result per cycle while out_ready=1.
- Backpressure:
  - out_valid=1 && out_ready=0 drops in_ready in the same cycle; in_ready is combinational from out_valid/out_ready.
  - sum, cout, ovf and zero stay stable while stalled.
- Simultaneous output transfer and input accept in one cycle is legal; the pipeline shifts by one.
- Reset:
  - On a rst=1 edge, all stage valid bits clear to 0 and all data registers clear to 0.
  - After reset: out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - in_ready=1 after reset.
- Reset mid-operation discards all in-flight items; no partial result is ever presented.
- in_valid is ignored during a rst=1 cycle.
- out_valid deasserts only after a transfer or on reset.

## Test plan
All scenarios use WIDTH=32, STAGES=2.

- Full carry chain: a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 → sum=0x00000000, cout=1, ovf=0, zero=1, out_valid 2 cycles after accept.
- Carry across segment boundary and signed overflow: back-to-back items a=0x0000FFFF+b=1 → 0x00010000, cout=0; then a=0x7FFFFFFF+b=1 → 0x80000000, ovf=1, cout=0. Results arrive on consecutive cycles.
- Subtract: a=5, b=7, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5, sub=1, cin=1 → sum=0x00000001, cout=1.
- Backpressure: stream of 6 items with out_ready held low for 3 cycles mid-stream → in_ready low during the stall, output data stable, all 6 results delivered in order with no loss or duplication.
- Reset mid-operation: accept 2 items, assert rst for 1 cycle before either is delivered → out_valid=0, sum=0 next cycle, no stale result ever appears, in_ready=1.
- Random: 10k random a, b, cin, sub with random in_valid/out_ready → results match a scoreboard computing (a ± b ± cin) mod 2^32, cout, and ovf; repeat with STAGES=1 and STAGES=8.

Source files
------------

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: 4-bit lookahead groups, group carries
// rippled within a segment, one segment per pipeline stage, valid/ready on both sides.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned SEGW = WIDTH / STAGES;
    localparam int unsigned GPS  = SEGW / 4;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Subtraction folds into addition of the inverted operand and inverted borrow.
    always_comb begin
        b_eff = sub ? ~b : b;
        c0    = sub ? ~cin : cin;
    end

    // Whole pipeline moves as one; stalls only when a presented result is refused.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // One segment: GPS lookahead groups, carry rippling group to group; returns {cout, sum}.
    function automatic logic [SEGW:0] seg_add(input logic [SEGW-1:0] x,
                                               input logic [SEGW-1:0] y,
                                               input logic            ci);
        logic [SEGW-1:0] p;
        logic [SEGW-1:0] g;
        logic [SEGW-1:0] s;
        logic [3:0]      gp;
        logic [3:0]      gg;
        logic            c;
        logic            c1;
        logic            c2;
        logic            c3;
        p = x ^ y;
        g = x & y;
        s = '0;
        c = ci;
        for (int i = 0; i < int'(GPS); i++) begin
            gp = p[4*i +: 4];
            gg = g[4*i +: 4];
            c1 = gg[0] | (gp[0] & c);
            c2 = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c);
            c3 = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & c);
            s[4*i +: 4] = gp ^ {c3, c2, c1, c};
            c  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & c);
        end
        return {c, s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned SW = (k + 1) * SEGW;
        localparam int unsigned RW = WIDTH - SW;

        logic             v_q;
        logic             c_q;
        logic [SW-1:0]    s_q;
        logic             v_d;
        logic             ci;
        logic [SW-1:0]    s_d;
        logic [RW+SEGW-1:0] src_a;
        logic [RW+SEGW-1:0] src_b;
        logic [SEGW:0]    r;

        // Operands not yet consumed travel with the item; finished sum bits ride along below.
        if (k == 0) begin : g_src
            assign v_d   = in_valid && in_ready;
            assign src_a = a;
            assign src_b = b_eff;
            assign ci    = c0;
            assign s_d   = r[SEGW-1:0];
        end else begin : g_src
            assign v_d   = g_st[k-1].v_q;
            assign src_a = g_st[k-1].g_fwd.a_q;
            assign src_b = g_st[k-1].g_fwd.b_q;
            assign ci    = g_st[k-1].c_q;
            assign s_d   = {r[SEGW-1:0], g_st[k-1].s_q};
        end

        assign r = seg_add(src_a[SEGW-1:0], src_b[SEGW-1:0], ci);

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                c_q <= r[SEGW];
                s_q <= s_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= src_a[RW+SEGW-1:SEGW];
                    b_q <= src_b[RW+SEGW-1:SEGW];
                end
            end
        end else begin : g_out
            logic ovf_q;
            logic zero_q;

            // Carry into the MSB is recovered as a^b'^sum at that bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= r[SEGW] ^ (src_a[SEGW-1] ^ src_b[SEGW-1] ^ r[SEGW-1]);
                    zero_q <= ~|s_d;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign sum       = g_st[STAGES-1].s_q;
    assign cout      = g_st[STAGES-1].c_q;
    assign ovf       = g_st[STAGES-1].g_out.ovf_q;
    assign zero      = g_st[STAGES-1].g_out.zero_q;

endmodule
